// File: rtl/lpc_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the LPC encoder CSR block.
package lpc_pkg;

  localparam logic [15:0] AddrFrameLen = 16'h0000;
  localparam logic [15:0] AddrCtrl     = 16'h0001;
  localparam logic [15:0] AddrStatus   = 16'h0002;
  localparam logic [15:0] AddrPitch    = 16'h0003;
  localparam logic [15:0] AddrCoefBase = 16'h0004;
  localparam logic [15:0] AddrFrameCnt = 16'h000F;

  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlIeBit  = 1;
  localparam int unsigned CtrlClrBit = 2;

  localparam int unsigned StatDoneBit   = 0;
  localparam int unsigned StatOvfBit    = 1;
  localparam int unsigned StatVoicedBit = 2;

endpackage

// File: rtl/lpc_coef_snapshot.sv
// Frame snapshot of encoder results (pitch, voiced flag, LPC coefficients).
module lpc_coef_snapshot #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_COEF = 11
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              capture,
  input  logic                              clear,
  input  logic [NUM_COEF*DATA_W-1:0]        coef_in,
  input  logic [DATA_W-1:0]                 pitch_in,
  input  logic                              voiced_in,
  output logic [NUM_COEF-1:0][DATA_W-1:0]   coef,
  output logic [DATA_W-1:0]                 pitch,
  output logic                              voiced
);

  logic [NUM_COEF-1:0][DATA_W-1:0] coef_q, coef_d;
  logic [DATA_W-1:0]               pitch_q, pitch_d;
  logic                            voiced_q, voiced_d;

  // Clear takes priority over a coincident capture.
  always_comb begin
    coef_d   = coef_q;
    pitch_d  = pitch_q;
    voiced_d = voiced_q;
    if (clear) begin
      coef_d   = '0;
      pitch_d  = '0;
      voiced_d = 1'b0;
    end else if (capture) begin
      coef_d   = coef_in;
      pitch_d  = pitch_in;
      voiced_d = voiced_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q   <= '0;
      pitch_q  <= '0;
      voiced_q <= 1'b0;
    end else begin
      coef_q   <= coef_d;
      pitch_q  <= pitch_d;
      voiced_q <= voiced_d;
    end
  end

  assign coef   = coef_q;
  assign pitch  = pitch_q;
  assign voiced = voiced_q;

endmodule

// File: rtl/lpc_csr_slave.sv
// Bus-facing CSR slave for the LPC encoder: config, status/irq and frame result readback.
module lpc_csr_slave
  import lpc_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned DEF_FRAME_LEN = 240,
  parameter int unsigned NUM_COEF      = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                address,
  input  logic                       read,
  input  logic                       write,
  input  logic [DATA_W-1:0]          writedata,
  output logic [DATA_W-1:0]          readdata,
  output logic                       readdatavalid,
  input  logic [NUM_COEF*DATA_W-1:0] coef_in,
  input  logic [DATA_W-1:0]          pitch_in,
  input  logic                       voiced_in,
  input  logic                       frame_strobe,
  output logic [DATA_W-1:0]          frame_len,
  output logic                       enc_enable,
  output logic                       irq
);

  logic [DATA_W-1:0] frame_len_q, frame_len_d;
  logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              en_q, en_d, ie_q, ie_d;
  logic              done_q, done_d, ovf_q, ovf_d;

  logic [NUM_COEF-1:0][DATA_W-1:0] snap_coef;
  logic [DATA_W-1:0]               snap_pitch;
  logic                            snap_voiced;

  logic capture, clear, rd;

  // A write in the same cycle as a read wins; the read is dropped.
  assign rd      = read & ~write;
  assign capture = frame_strobe & en_q;
  assign clear   = write && (address == AddrCtrl) && writedata[CtrlClrBit];

  lpc_coef_snapshot #(
    .DATA_W   (DATA_W),
    .NUM_COEF (NUM_COEF)
  ) u_snapshot (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .clear     (clear),
    .coef_in   (coef_in),
    .pitch_in  (pitch_in),
    .voiced_in (voiced_in),
    .coef      (snap_coef),
    .pitch     (snap_pitch),
    .voiced    (snap_voiced)
  );

  always_comb begin
    frame_len_d = frame_len_q;
    frame_cnt_d = frame_cnt_q;
    en_d        = en_q;
    ie_d        = ie_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    if (write && address == AddrFrameLen && writedata != '0) frame_len_d = writedata;
    if (write && address == AddrCtrl) begin
      en_d = writedata[CtrlEnBit];
      ie_d = writedata[CtrlIeBit];
    end
    if (write && address == AddrStatus) begin
      if (writedata[StatDoneBit]) done_d = 1'b0;
      if (writedata[StatOvfBit])  ovf_d  = 1'b0;
    end
    // Capture is applied after W1C so a coincident set wins.
    if (capture) begin
      done_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 1'b1;
      if (done_q) ovf_d = 1'b1;
    end
    if (clear) begin
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      frame_cnt_d = '0;
    end
  end

  always_comb begin
    rdata_d  = '0;
    rvalid_d = rd;
    if (rd) begin
      if (address == AddrFrameLen) rdata_d = frame_len_q;
      if (address == AddrCtrl) begin
        rdata_d[CtrlEnBit] = en_q;
        rdata_d[CtrlIeBit] = ie_q;
      end
      if (address == AddrStatus) begin
        rdata_d[StatDoneBit]   = done_q;
        rdata_d[StatOvfBit]    = ovf_q;
        rdata_d[StatVoicedBit] = snap_voiced;
      end
      if (address == AddrPitch) rdata_d = snap_pitch;
      for (int i = 0; i < int'(NUM_COEF); i++) begin
        if (address == 16'(AddrCoefBase + 16'(i))) rdata_d = snap_coef[i];
      end
      if (address == AddrFrameCnt) rdata_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_len_q <= DATA_W'(DEF_FRAME_LEN);
      frame_cnt_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      frame_len_q <= frame_len_d;
      frame_cnt_q <= frame_cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign frame_len     = frame_len_q;
  assign enc_enable    = en_q;
  assign irq           = done_q & ie_q;

endmodule
